// File: rtl/mau_pkg.sv
// Shared types and helpers for the data-memory access unit (mem_access_unit).
// Optional build macro used by the top: MAU_UNALIGNED_TRAP_EN.
package mau_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } mau_state_t;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  function automatic logic is_half(input mem_op_t op);
    return op inside {LH, LHU, SH};
  endfunction

  function automatic logic is_word(input mem_op_t op);
    return op inside {LW, SW};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/mau_if.sv
// Request/response handshake between the MEM pipeline stage (master) and the access unit (slave).
interface mau_if;
  import mau_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mau_lane_unit.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module mau_lane_unit
  import mau_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  shift;
  logic [31:0] lane;

  assign shift = {addr_lo, 3'b000};
  assign lane  = rdata >> shift;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    load_data  = '0;
    store_word = rdata;
    unique case (op)
      LB:  load_data = {{24{lane[7]}}, lane[7:0]};
      LBU: load_data = lane & BYTE_MASK;
      LH:  load_data = {{16{lane[15]}}, lane[15:0]};
      LHU: load_data = lane & HALF_MASK;
      LW:  load_data = rdata;
      SB:  store_word = (rdata & ~(BYTE_MASK << shift)) | ((wdata & BYTE_MASK) << shift);
      SH:  store_word = (rdata & ~(HALF_MASK << shift)) | ((wdata & HALF_MASK) << shift);
      SW:  store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: one request at a time, RMW for sub-word stores.
// Build macro MAU_UNALIGNED_TRAP_EN: defined -> misaligned accesses error; undefined -> force-aligned.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  mau_if.slave        bus,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  localparam logic [32:0] DM_LIMIT = 33'(DM_DEPTH * 4);

  mau_state_t  state;
  mem_op_t     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        req_err;
  logic [31:0] eff_addr;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

`ifdef MAU_UNALIGNED_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half(bus.req_op) & bus.req_addr[0])
                    | (is_word(bus.req_op) & (|bus.req_addr[1:0]));
  assign req_err  = misaligned | ({1'b0, bus.req_addr} >= DM_LIMIT);
  assign eff_addr = bus.req_addr;
`else
  assign req_err = ({1'b0, bus.req_addr} >= DM_LIMIT);
  always_comb begin
    eff_addr = bus.req_addr;
    if (is_word(bus.req_op))      eff_addr[1:0] = 2'b00;
    else if (is_half(bus.req_op)) eff_addr[0]   = 1'b0;
  end
`endif

  mau_lane_unit u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (dm_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= LB;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_read      <= 1'b0;
      dm_write     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          addr_q  <= eff_addr;
          wdata_q <= bus.req_wdata;
          ready_q <= 1'b0;
          if (req_err) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end else if (bus.req_op == SW) begin
            state    <= WRITE;
            dm_write <= 1'b1;
            dm_addr  <= eff_addr;
            dm_wdata <= bus.req_wdata;
          end else begin
            state   <= READ;
            dm_read <= 1'b1;
            dm_addr <= eff_addr;
          end
        end
        READ: begin
          dm_read <= 1'b0;
          if (is_store(op_q)) begin
            // Sub-word store: the merged word is captured here and written next cycle.
            state    <= WRITE;
            dm_write <= 1'b1;
            dm_wdata <= store_word;
          end else begin
            state        <= RESP;
            dm_addr      <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
          end
        end
        WRITE: begin
          state        <= RESP;
          dm_write     <= 1'b0;
          dm_wdata     <= '0;
          dm_addr      <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a response scoreboard.
module tb_mem_access_unit;
  import mau_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] mem [256];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  int          rw_overlap = 0;

  always #5 clk = ~clk;

  mau_if bus ();

  mem_access_unit #(.DM_DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_rdata (dm_rdata)
  );

  // Memory model: combinational read while enabled, write on the falling edge.
  assign dm_rdata = dm_read ? mem[dm_addr[9:2]] : 32'hzzzz_zzzz;
  always @(negedge clk) if (dm_write === 1'b1) mem[dm_addr[9:2]] <= dm_wdata;
  always @(negedge clk) if (dm_read === 1'b1 && dm_write === 1'b1) rw_overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int rd, input int wr, input logic [31:0] waddr,
                              input logic [31:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.rd_cnt = rd; e.wr_cnt = wr;
    e.waddr = waddr; e.wdata = wdata;
    return e;
  endfunction

  task automatic wait_ready(input string name);
    int guard = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({name, " ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input string name, input mem_op_t op, input logic [31:0] addr,
                        input logic [31:0] wdata, input exp_t e);
    exp_t        got;
    int          lat = 1;
    int          rd = 0;
    int          wr = 0;
    logic [31:0] waddr = '0;
    logic [31:0] wd = '0;
    sb.push_back(e);
    wait_ready(name);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      if (dm_read === 1'b1) rd++;
      if (dm_write === 1'b1) begin
        wr++;
        waddr = dm_addr;
        wd    = dm_wdata;
      end
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check({name, " latency"}, 32'(lat), 32'(got.lat));
    check({name, " rdata"}, bus.resp_rdata, got.rdata);
    check({name, " err"}, 32'(bus.resp_err), 32'(got.err));
    check({name, " reads"}, 32'(rd), 32'(got.rd_cnt));
    check({name, " writes"}, 32'(wr), 32'(got.wr_cnt));
    if (got.wr_cnt != 0) begin
      check({name, " dm_addr"}, waddr, got.waddr);
      check({name, " dm_wdata"}, wd, got.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_seen = 0;
    int rv_seen = 0;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]   = 32'hCAFE_F00D;
    mem[8]   = 32'h5566_7788;
    mem[9]   = 32'h99AA_BBCC;
    mem[255] = 32'h0BAD_F00D;
    bus.req_valid = 1'b0;
    bus.req_op    = LB;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst dm_read", 32'(dm_read), 32'd0);
    check("rst dm_write", 32'(dm_write), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst dm_addr", dm_addr, 32'd0);
    rst = 1'b0;

    do_req("sw10", SW, 32'h10, 32'hDEAD_BEEF, mk(32'h0, 1'b0, 2, 0, 1, 32'h10, 32'hDEAD_BEEF));
    do_req("lw10", LW, 32'h10, 32'h0, mk(32'hDEAD_BEEF, 1'b0, 2, 1, 0, 0, 0));
    do_req("sw10b", SW, 32'h10, 32'h1122_3344, mk(32'h0, 1'b0, 2, 0, 1, 32'h10, 32'h1122_3344));
    do_req("sb13", SB, 32'h13, 32'h0000_00A5, mk(32'h0, 1'b0, 3, 1, 1, 32'h13, 32'hA522_3344));
    do_req("lb13", LB, 32'h13, 32'h0, mk(32'hFFFF_FFA5, 1'b0, 2, 1, 0, 0, 0));
    do_req("lbu13", LBU, 32'h13, 32'h0, mk(32'h0000_00A5, 1'b0, 2, 1, 0, 0, 0));
    do_req("sh12", SH, 32'h12, 32'h0000_8001, mk(32'h0, 1'b0, 3, 1, 1, 32'h12, 32'h8001_3344));
    do_req("lh12", LH, 32'h12, 32'h0, mk(32'hFFFF_8001, 1'b0, 2, 1, 0, 0, 0));
    do_req("lhu12", LHU, 32'h12, 32'h0, mk(32'h0000_8001, 1'b0, 2, 1, 0, 0, 0));
    do_req("lb10", LB, 32'h10, 32'h0, mk(32'h0000_0044, 1'b0, 2, 1, 0, 0, 0));
    do_req("lb11", LB, 32'h11, 32'h0, mk(32'h0000_0033, 1'b0, 2, 1, 0, 0, 0));
`ifdef MAU_UNALIGNED_TRAP_EN
    do_req("lw02", LW, 32'h02, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    do_req("sh21", SH, 32'h21, 32'h0000_1234, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
`else
    do_req("lw02", LW, 32'h02, 32'h0, mk(32'hCAFE_F00D, 1'b0, 2, 1, 0, 0, 0));
    do_req("sh21", SH, 32'h21, 32'h0000_1234, mk(32'h0, 1'b0, 3, 1, 1, 32'h20, 32'h5566_1234));
`endif
    do_req("lw400", LW, 32'h400, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    do_req("sw400", SW, 32'h400, 32'h1234_5678, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    do_req("lw3fc", LW, 32'h3FC, 32'h0, mk(32'h0BAD_F00D, 1'b0, 2, 1, 0, 0, 0));
    check("mem word 0x10", mem[4], 32'h8001_3344);

    // Reset lands while an SB sits in its READ cycle.
    wait_ready("sb24");
    bus.req_valid = 1'b1;
    bus.req_op    = SB;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'h0000_0077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midrst dm_read", 32'(dm_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst dm_read off", 32'(dm_read), 32'd0);
    check("midrst dm_write", 32'(dm_write), 32'd0);
    check("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dm_write === 1'b1) wr_seen++;
      if (bus.resp_valid === 1'b1) rv_seen++;
    end
    check("midrst late writes", 32'(wr_seen), 32'd0);
    check("midrst late resp", 32'(rv_seen), 32'd0);
    check("midrst mem word 0x24", mem[9], 32'h99AA_BBCC);
    check("rd/wr overlap", 32'(rw_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
